// File: rtl/ser_rr_sched_pkg.sv
// ============================================================================
// Module   : ser_rr_sched_pkg
// Purpose  : Shared types, widths and helpers for the serializer scheduler.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

package ser_rr_sched_pkg;

  localparam int DATA_W = 16;
  localparam int MOD_W  = 4;

  localparam logic [MOD_W-1:0] MOD_FULL = 4'd0;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    LOAD  = 3'd1,
    ISSUE = 3'd2,
    CHECK = 3'd3,
    WAIT  = 3'd4
  } state_t;

  // Bit counts of 1 or 2 cannot be framed by the serializer.
  function automatic logic mod_illegal(input logic [MOD_W-1:0] mod);
    return (mod == 4'd1) || (mod == 4'd2);
  endfunction

endpackage

`default_nettype wire

// File: rtl/rr_arbiter.sv
// ============================================================================
// Module   : rr_arbiter
// Purpose  : Combinational round-robin pick, searching upward from ptr.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module rr_arbiter #(
  parameter int N_REQ = 4,
  parameter int ID_W  = $clog2(N_REQ)
) (
  input  logic [N_REQ-1:0] req,
  input  logic [ID_W-1:0]  ptr,
  output logic [N_REQ-1:0] gnt,
  output logic [ID_W-1:0]  gnt_id,
  output logic             any
);

  logic [ID_W-1:0] w_idx;

  always_comb begin
    gnt    = '0;
    gnt_id = '0;
    any    = 1'b0;
    w_idx  = ptr;
    for (int i = 0; i < N_REQ; i++) begin
      if (!any && req[w_idx]) begin
        any         = 1'b1;
        gnt[w_idx]  = 1'b1;
        gnt_id      = w_idx;
      end
      // Wrap explicitly so non-power-of-two requester counts stay in range.
      w_idx = (w_idx == ID_W'(N_REQ - 1)) ? '0 : w_idx + 1'b1;
    end
  end

endmodule

`default_nettype wire

// File: rtl/ser_rr_sched.sv
// ============================================================================
// Module   : ser_rr_sched
// Purpose  : Round-robin sharing of one 16-bit serializer among N_REQ sources.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module ser_rr_sched
  import ser_rr_sched_pkg::*;
#(
  parameter int N_REQ = 4,
  parameter int ID_W  = $clog2(N_REQ)
) (
  input  logic                          clk_i,
  input  logic                          arst_i,
  input  logic [N_REQ-1:0][DATA_W-1:0]  req_data_i,
  input  logic [N_REQ-1:0][MOD_W-1:0]   req_mod_i,
  input  logic [N_REQ-1:0]              req_val_i,
  output logic [N_REQ-1:0]              req_ready_o,
  output logic [DATA_W-1:0]             ser_data_o,
  output logic [MOD_W-1:0]              ser_mod_o,
  output logic                          ser_val_o,
  input  logic                          ser_busy_i,
  output logic [ID_W-1:0]               grant_id_o,
  output logic                          owner_val_o,
  output logic                          drop_o,
  output logic                          err_o
);

  state_t              r_state;
  state_t              w_state_nxt;
  logic [ID_W-1:0]     r_ptr;
  logic [DATA_W-1:0]   r_data;
  logic [MOD_W-1:0]    r_mod;
  logic [ID_W-1:0]     r_id;

  logic [N_REQ-1:0]    w_gnt;
  logic [ID_W-1:0]     w_gnt_id;
  logic                w_any;
  logic                w_xfer;

  rr_arbiter #(
    .N_REQ (N_REQ),
    .ID_W  (ID_W)
  ) u_arb (
    .req    (req_val_i),
    .ptr    (r_ptr),
    .gnt    (w_gnt),
    .gnt_id (w_gnt_id),
    .any    (w_any)
  );

  // Ready is gated by reset so that every output reads zero while it is held.
  assign req_ready_o = ((r_state == IDLE) && !arst_i) ? w_gnt : '0;
  assign w_xfer      = (r_state == IDLE) && w_any;

  assign ser_data_o  = r_data;
  assign ser_mod_o   = r_mod;
  assign grant_id_o  = r_id;
  assign owner_val_o = (r_state != IDLE);

  always_ff @(posedge clk_i or posedge arst_i) begin
    if (arst_i) begin
      r_state <= IDLE;
      r_ptr   <= '0;
      r_data  <= '0;
      r_mod   <= '0;
      r_id    <= '0;
    end else begin
      r_state <= w_state_nxt;
      if (w_xfer) begin
        r_data <= req_data_i[w_gnt_id];
        r_mod  <= req_mod_i[w_gnt_id];
        r_id   <= w_gnt_id;
        r_ptr  <= (w_gnt_id == ID_W'(N_REQ - 1)) ? '0 : w_gnt_id + 1'b1;
      end
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    ser_val_o   = 1'b0;
    drop_o      = 1'b0;
    err_o       = 1'b0;
    unique case (r_state)
      IDLE: begin
        if (w_any) w_state_nxt = LOAD;
      end
      LOAD: begin
        if (mod_illegal(r_mod)) begin
          drop_o      = 1'b1;
          w_state_nxt = IDLE;
        end else begin
          w_state_nxt = ISSUE;
        end
      end
      ISSUE: begin
        ser_val_o   = 1'b1;
        w_state_nxt = CHECK;
      end
      CHECK: begin
        // The serializer must have raised busy one cycle after data_val.
        if (ser_busy_i) begin
          w_state_nxt = WAIT;
        end else begin
          err_o       = 1'b1;
          w_state_nxt = IDLE;
        end
      end
      WAIT: begin
        if (!ser_busy_i) w_state_nxt = IDLE;
      end
      default: w_state_nxt = IDLE;
    endcase
  end

endmodule

`default_nettype wire

// File: tb/tb_ser_rr_sched.sv
// ============================================================================
// Module   : tb_ser_rr_sched
// Purpose  : Self-checking bench for ser_rr_sched with a busy-counting serializer stub.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_ser_rr_sched;

  localparam int N = 4;

  logic              clk_i = 1'b0;
  logic              arst_i = 1'b0;
  logic [N-1:0][15:0] req_data_i;
  logic [N-1:0][3:0]  req_mod_i;
  logic [N-1:0]      req_val_i;
  logic [N-1:0]      req_ready_o;
  logic [15:0]       ser_data_o;
  logic [3:0]        ser_mod_o;
  logic              ser_val_o;
  logic              ser_busy_i;
  logic [1:0]        grant_id_o;
  logic              owner_val_o;
  logic              drop_o;
  logic              err_o;

  int n_cmp  = 0;
  int n_fail = 0;
  int blen   = 4;
  int bcnt   = 0;

  ser_rr_sched #(.N_REQ(N)) dut (
    .clk_i       (clk_i),
    .arst_i      (arst_i),
    .req_data_i  (req_data_i),
    .req_mod_i   (req_mod_i),
    .req_val_i   (req_val_i),
    .req_ready_o (req_ready_o),
    .ser_data_o  (ser_data_o),
    .ser_mod_o   (ser_mod_o),
    .ser_val_o   (ser_val_o),
    .ser_busy_i  (ser_busy_i),
    .grant_id_o  (grant_id_o),
    .owner_val_o (owner_val_o),
    .drop_o      (drop_o),
    .err_o       (err_o)
  );

  always #5 clk_i = ~clk_i;

  // Serializer stub: busy for blen cycles after each data_val (blen 0 = never busy).
  always @(posedge clk_i or posedge arst_i) begin
    if (arst_i)                       bcnt <= 0;
    else if (ser_val_o && blen != 0)  bcnt <= blen;
    else if (bcnt != 0)               bcnt <= bcnt - 1;
  end
  assign ser_busy_i = (bcnt != 0);

  function automatic int rr_pick(input int p, input logic [N-1:0] m);
    logic [N-1:0] t;
    for (int i = 0; i < N; i++) begin
      t = m >> ((p + i) % N);
      if (t[0]) return (p + i) % N;
    end
    return -1;
  endfunction

  task automatic nxt();
    @(posedge clk_i);
    #1;
  endtask

  task automatic do_reset();
    nxt();
    arst_i = 1'b1;
    req_val_i = '0;
    nxt();
    nxt();
    arst_i = 1'b0;
  endtask

  task automatic test_reset();
    do_reset();
    req_data_i[1] = 16'h1234; req_mod_i[1] = 4'd5; req_val_i = 4'b0010; blen = 16;
    #2;
    n_cmp++; if (req_ready_o !== 4'b0010) begin n_fail++; $display("FAIL reset_first_ready: got %b exp 0010", req_ready_o); end
    nxt(); req_val_i = 4'b1111; #2;
    n_cmp++; if (owner_val_o !== 1'b1 || req_ready_o !== 4'b0000) begin n_fail++; $display("FAIL reset_load: owner %b ready %b exp 1/0000", owner_val_o, req_ready_o); end
    nxt(); #2;
    n_cmp++; if (ser_val_o !== 1'b1 || ser_data_o !== 16'h1234) begin n_fail++; $display("FAIL reset_issue: val %b data %h exp 1/1234", ser_val_o, ser_data_o); end
    #2; arst_i = 1'b1; #1;
    n_cmp++; if ({ser_val_o, owner_val_o, drop_o, err_o} !== 4'b0000) begin n_fail++; $display("FAIL reset_async_flags: got %b exp 0000", {ser_val_o, owner_val_o, drop_o, err_o}); end
    n_cmp++; if ({ser_data_o, ser_mod_o, grant_id_o} !== 22'd0) begin n_fail++; $display("FAIL reset_async_latches: data %h mod %h id %0d exp 0", ser_data_o, ser_mod_o, grant_id_o); end
    n_cmp++; if (req_ready_o !== 4'b0000) begin n_fail++; $display("FAIL reset_async_ready: got %b exp 0000", req_ready_o); end
    nxt(); arst_i = 1'b0; req_val_i = 4'b0110; #2;
    n_cmp++; if (req_ready_o !== 4'b0010) begin n_fail++; $display("FAIL reset_ptr_zero: got %b exp 0010", req_ready_o); end
  endtask

  task automatic test_single_word();
    int bad;
    do_reset();
    blen = 16;
    req_data_i[2] = 16'hA5C3; req_mod_i[2] = 4'd0; req_val_i = 4'b0100;
    #2;
    n_cmp++; if (req_ready_o !== 4'b0100) begin n_fail++; $display("FAIL single_ready: got %b exp 0100", req_ready_o); end
    nxt(); req_val_i = '0; #2;
    n_cmp++; if (owner_val_o !== 1'b1 || grant_id_o !== 2'd2 || ser_val_o !== 1'b0) begin n_fail++; $display("FAIL single_load: owner %b id %0d val %b exp 1/2/0", owner_val_o, grant_id_o, ser_val_o); end
    nxt(); #2;
    n_cmp++; if (ser_val_o !== 1'b1 || ser_data_o !== 16'hA5C3 || ser_mod_o !== 4'd0) begin n_fail++; $display("FAIL single_issue: val %b data %h mod %0d exp 1/a5c3/0", ser_val_o, ser_data_o, ser_mod_o); end
    bad = 0;
    for (int c = 3; c < 20; c++) begin
      nxt(); req_val_i = 4'b0001; #2;
      n_cmp++;
      if (owner_val_o !== 1'b1 || ser_val_o !== 1'b0 || req_ready_o !== 4'b0000) begin
        n_fail++; $display("FAIL single_hold c%0d: owner %b val %b ready %b exp 1/0/0000", c, owner_val_o, ser_val_o, req_ready_o);
      end
    end
    nxt(); #2;
    n_cmp++; if (owner_val_o !== 1'b0 || req_ready_o !== 4'b0001) begin n_fail++; $display("FAIL single_idle: owner %b ready %b exp 0/0001", owner_val_o, req_ready_o); end
    n_cmp++; if (ser_data_o !== 16'hA5C3) begin n_fail++; $display("FAIL single_data_hold: got %h exp a5c3", ser_data_o); end
  endtask

  task automatic test_round_robin();
    int exp_order [6] = '{0, 1, 3, 0, 1, 3};
    int k;
    do_reset();
    blen = 4;
    for (int r = 0; r < N; r++) begin
      req_data_i[r] = 16'h1000 + 16'(r);
      req_mod_i[r]  = 4'd4;
    end
    req_val_i = 4'b1011;
    k = 0;
    for (int c = 0; c < 200 && k < 6; c++) begin
      #2;
      n_cmp++; if (ser_val_o && ser_busy_i) begin n_fail++; $display("FAIL rr_overlap c%0d: val %b busy %b exp no overlap", c, ser_val_o, ser_busy_i); end
      if (ser_val_o) begin
        n_cmp++;
        if (grant_id_o !== 2'(exp_order[k]) || ser_data_o !== 16'h1000 + 16'(exp_order[k]) || ser_mod_o !== 4'd4) begin
          n_fail++; $display("FAIL rr_grant%0d: id %0d data %h mod %0d exp id %0d", k, grant_id_o, ser_data_o, ser_mod_o, exp_order[k]);
        end
        k++;
      end
      nxt();
    end
    n_cmp++; if (k != 6) begin n_fail++; $display("FAIL rr_count: got %0d grants exp 6", k); end
  endtask

  task automatic test_illegal_mod();
    do_reset();
    blen = 4;
    req_data_i[1] = 16'hBEEF; req_mod_i[1] = 4'd1; req_val_i = 4'b0010;
    req_data_i[0] = 16'h0001; req_mod_i[0] = 4'd8;
    req_data_i[2] = 16'h0002; req_mod_i[2] = 4'd8;
    #2;
    n_cmp++; if (req_ready_o !== 4'b0010) begin n_fail++; $display("FAIL drop_ready: got %b exp 0010", req_ready_o); end
    nxt(); req_val_i = 4'b0101; #2;
    n_cmp++; if (drop_o !== 1'b1 || ser_val_o !== 1'b0 || owner_val_o !== 1'b1) begin n_fail++; $display("FAIL drop_pulse: drop %b val %b owner %b exp 1/0/1", drop_o, ser_val_o, owner_val_o); end
    n_cmp++; if (req_ready_o !== 4'b0000) begin n_fail++; $display("FAIL drop_ready_busy: got %b exp 0000", req_ready_o); end
    nxt(); #2;
    n_cmp++; if (drop_o !== 1'b0 || ser_val_o !== 1'b0 || owner_val_o !== 1'b0) begin n_fail++; $display("FAIL drop_idle: drop %b val %b owner %b exp 0/0/0", drop_o, ser_val_o, owner_val_o); end
    n_cmp++; if (req_ready_o !== 4'b0100) begin n_fail++; $display("FAIL drop_next_grant: got %b exp 0100", req_ready_o); end
    n_cmp++; if (ser_data_o !== 16'hBEEF || ser_mod_o !== 4'd1) begin n_fail++; $display("FAIL drop_latch: data %h mod %0d exp beef/1", ser_data_o, ser_mod_o); end
  endtask

  task automatic test_no_busy();
    do_reset();
    blen = 0;
    req_data_i[0] = 16'h5A5A; req_mod_i[0] = 4'd8; req_val_i = 4'b0001;
    #2;
    n_cmp++; if (req_ready_o !== 4'b0001) begin n_fail++; $display("FAIL nobusy_ready: got %b exp 0001", req_ready_o); end
    nxt(); req_val_i = '0;
    nxt(); #2;
    n_cmp++; if (ser_val_o !== 1'b1 || err_o !== 1'b0) begin n_fail++; $display("FAIL nobusy_issue: val %b err %b exp 1/0", ser_val_o, err_o); end
    nxt(); req_val_i = 4'b0011; #2;
    n_cmp++; if (err_o !== 1'b1 || owner_val_o !== 1'b1 || req_ready_o !== 4'b0000) begin n_fail++; $display("FAIL nobusy_err: err %b owner %b ready %b exp 1/1/0000", err_o, owner_val_o, req_ready_o); end
    nxt(); #2;
    n_cmp++; if (err_o !== 1'b0 || owner_val_o !== 1'b0) begin n_fail++; $display("FAIL nobusy_idle: err %b owner %b exp 0/0", err_o, owner_val_o); end
    n_cmp++; if (req_ready_o !== 4'b0010) begin n_fail++; $display("FAIL nobusy_ptr: got %b exp 0010", req_ready_o); end
  endtask

  task automatic test_reset_mid_wait();
    do_reset();
    blen = 16;
    req_data_i[2] = 16'h0F0F; req_mod_i[2] = 4'd0; req_val_i = 4'b0100;
    for (int c = 0; c < 5; c++) begin
      nxt(); req_val_i = 4'b1010;
    end
    #2;
    n_cmp++; if (owner_val_o !== 1'b1 || ser_busy_i !== 1'b1 || req_ready_o !== 4'b0000) begin n_fail++; $display("FAIL rstwait_pre: owner %b busy %b ready %b exp 1/1/0000", owner_val_o, ser_busy_i, req_ready_o); end
    #2; arst_i = 1'b1; #1;
    n_cmp++; if (owner_val_o !== 1'b0 || req_ready_o !== 4'b0000) begin n_fail++; $display("FAIL rstwait_async: owner %b ready %b exp 0/0000", owner_val_o, req_ready_o); end
    n_cmp++; if (ser_data_o !== 16'h0 || grant_id_o !== 2'd0) begin n_fail++; $display("FAIL rstwait_latch: data %h id %0d exp 0/0", ser_data_o, grant_id_o); end
    nxt(); arst_i = 1'b0; req_val_i = 4'b1111; #2;
    n_cmp++; if (req_ready_o !== 4'b0001) begin n_fail++; $display("FAIL rstwait_first: got %b exp 0001", req_ready_o); end
    nxt(); req_val_i = 4'b1110; #2;
    n_cmp++; if (owner_val_o !== 1'b1 || grant_id_o !== 2'd0) begin n_fail++; $display("FAIL rstwait_owner: owner %b id %0d exp 1/0", owner_val_o, grant_id_o); end
  endtask

  // Transaction-level model: each accepted word fixes its own event cycles relative to handshake.
  task automatic test_random();
    logic [15:0]  wd [N];
    logic [3:0]   wm [N];
    logic [N-1:0] vmask, exp_rdy;
    logic [15:0]  lat_d;
    logic [3:0]   lat_m;
    int ptr_m, lat_id, hs, idle_at, p;
    bit legal, exp_own, exp_val, exp_drop, exp_err;
    do_reset();
    vmask = '0; ptr_m = 0; lat_d = '0; lat_m = '0; lat_id = 0;
    hs = -100; idle_at = 0; legal = 1'b1; blen = 3;
    for (int r = 0; r < N; r++) begin wd[r] = '0; wm[r] = '0; end
    for (int c = 0; c < 1500; c++) begin
      for (int r = 0; r < N; r++) begin
        if (!vmask[r] && $urandom_range(0, 3) == 0) begin
          vmask[r] = 1'b1;
          wd[r] = 16'($urandom);
          wm[r] = 4'($urandom_range(0, 15));
        end
        req_data_i[r] = wd[r];
        req_mod_i[r]  = wm[r];
      end
      req_val_i = vmask;
      #2;
      p        = rr_pick(ptr_m, vmask);
      exp_rdy  = (c >= idle_at && p >= 0) ? (N'(1) << p) : '0;
      exp_own  = (c > hs) && (c < idle_at);
      exp_val  = legal && (c == hs + 2);
      exp_drop = !legal && (c == hs + 1);
      exp_err  = legal && (blen == 0) && (c == hs + 3);
      n_cmp++; if (req_ready_o !== exp_rdy) begin n_fail++; $display("FAIL rnd_ready c%0d: got %b exp %b", c, req_ready_o, exp_rdy); end
      n_cmp++; if ({owner_val_o, ser_val_o, drop_o, err_o} !== {exp_own, exp_val, exp_drop, exp_err}) begin
        n_fail++; $display("FAIL rnd_flags c%0d: own/val/drop/err got %b exp %b", c, {owner_val_o, ser_val_o, drop_o, err_o}, {exp_own, exp_val, exp_drop, exp_err});
      end
      n_cmp++; if (ser_data_o !== lat_d || ser_mod_o !== lat_m || grant_id_o !== 2'(lat_id)) begin
        n_fail++; $display("FAIL rnd_latch c%0d: data %h mod %0d id %0d exp %h %0d %0d", c, ser_data_o, ser_mod_o, grant_id_o, lat_d, lat_m, lat_id);
      end
      n_cmp++; if (ser_val_o && ser_busy_i) begin n_fail++; $display("FAIL rnd_overlap c%0d: val %b busy %b exp no overlap", c, ser_val_o, ser_busy_i); end
      if (exp_rdy != '0) begin
        hs      = c;
        legal   = !((wm[p] == 4'd1) || (wm[p] == 4'd2));
        blen    = ($urandom_range(0, 5) == 0) ? 0 : int'($urandom_range(1, 8));
        idle_at = legal ? hs + 4 + blen : hs + 2;
        lat_d   = wd[p];
        lat_m   = wm[p];
        lat_id  = p;
        ptr_m   = (p + 1) % N;
        vmask[p] = 1'b0;
      end
      nxt();
    end
  endtask

  initial begin
    req_data_i = '0;
    req_mod_i  = '0;
    req_val_i  = '0;
    test_reset();
    test_single_word();
    test_round_robin();
    test_illegal_mod();
    test_no_busy();
    test_reset_mid_wait();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule

`default_nettype wire
